// File: rtl/gb_apu_envelope_multi.sv
// Multi-channel Game Boy APU volume envelope: NUM_CH independent saturating envelopes on one shared tick.
// Optional zombie-mode config writes are compiled in by defining GB_APU_ENV_ZOMBIE_EN.

module gb_apu_env_lane #(
   parameter int VOL_W = 4,
   parameter int PER_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             start,
   input  logic             cfg_wr,
   input  logic [VOL_W-1:0] init_vol,
   input  logic             inc,
   input  logic [PER_W-1:0] period,
   output logic [VOL_W-1:0] vol,
   output logic             done
);
   localparam logic [VOL_W-1:0] VMAX = '1;

   logic [PER_W-1:0] cnt;
   logic [PER_W-1:0] per;
   logic             dir;
   logic             at_limit;

   assign at_limit = dir ? (vol == VMAX) : (vol == '0);

`ifdef GB_APU_ENV_ZOMBIE_EN
   // Hardware quirk: rewriting config on a live channel corrupts volume, all wrapping.
   logic [VOL_W-1:0] zvol;
   always_comb begin
      zvol = vol;
      if (per == '0 && !done) zvol = zvol + 1'b1;
      else if (!dir)          zvol = zvol + VOL_W'(2);
      if (inc != dir)         zvol = '0 - zvol;
   end
`else
   logic unused_cfg_wr;
   assign unused_cfg_wr = cfg_wr;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vol  <= '0;
         cnt  <= '0;
         per  <= '0;
         dir  <= 1'b0;
         done <= 1'b0;
      end else if (start) begin
         vol  <= init_vol;
         per  <= period;
         dir  <= inc;
         cnt  <= period;
         done <= 1'b0;
      end
`ifdef GB_APU_ENV_ZOMBIE_EN
      else if (cfg_wr) begin
         vol <= zvol;
         per <= period;
         dir <= inc;
      end
`endif
      else if (tick && per != '0 && !done) begin
         if (cnt > PER_W'(1)) begin
            cnt <= cnt - 1'b1;
         end else begin
            // Once saturated the channel freezes until the next start.
            cnt <= per;
            if (at_limit)  done <= 1'b1;
            else if (dir)  vol  <= vol + 1'b1;
            else           vol  <= vol - 1'b1;
         end
      end
   end
endmodule

module gb_apu_envelope_multi #(
   parameter int NUM_CH = 3,
   parameter int VOL_W  = 4,
   parameter int PER_W  = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clk_vol_env,
   input  logic [NUM_CH-1:0]       start,
   input  logic [NUM_CH-1:0]       cfg_wr,
   input  logic [NUM_CH*VOL_W-1:0] initial_volume,
   input  logic [NUM_CH-1:0]       envelope_increasing,
   input  logic [NUM_CH*PER_W-1:0] num_envelope_sweeps,
   output logic [NUM_CH*VOL_W-1:0] target_vol,
   output logic [NUM_CH-1:0]       env_done,
   output logic [NUM_CH-1:0]       dac_off
);
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      gb_apu_env_lane #(
         .VOL_W (VOL_W),
         .PER_W (PER_W)
      ) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .tick     (clk_vol_env),
         .start    (start[c]),
         .cfg_wr   (cfg_wr[c]),
         .init_vol (initial_volume[c*VOL_W +: VOL_W]),
         .inc      (envelope_increasing[c]),
         .period   (num_envelope_sweeps[c*PER_W +: PER_W]),
         .vol      (target_vol[c*VOL_W +: VOL_W]),
         .done     (env_done[c])
      );

      // DAC power follows the live register inputs, not the latched envelope.
      assign dac_off[c] = (initial_volume[c*VOL_W +: VOL_W] == '0) && !envelope_increasing[c];
   end
endmodule

// File: tb/tb_gb_apu_envelope_multi.sv
// Scoreboard bench for gb_apu_envelope_multi: tick-count reference model feeds an expectation queue.
module tb_gb_apu_envelope_multi;
   localparam int NUM_CH = 3;
   localparam int VOL_W  = 4;
   localparam int PER_W  = 3;
   localparam int VMAX   = (1 << VOL_W) - 1;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    clk_vol_env = 1'b0;
   logic [NUM_CH-1:0]       start = '0;
   logic [NUM_CH-1:0]       cfg_wr = '0;
   logic [NUM_CH*VOL_W-1:0] initial_volume = '0;
   logic [NUM_CH-1:0]       envelope_increasing = '0;
   logic [NUM_CH*PER_W-1:0] num_envelope_sweeps = '0;
   logic [NUM_CH*VOL_W-1:0] target_vol;
   logic [NUM_CH-1:0]       env_done;
   logic [NUM_CH-1:0]       dac_off;

   gb_apu_envelope_multi #(.NUM_CH(NUM_CH), .VOL_W(VOL_W), .PER_W(PER_W)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .clk_vol_env         (clk_vol_env),
      .start               (start),
      .cfg_wr              (cfg_wr),
      .initial_volume      (initial_volume),
      .envelope_increasing (envelope_increasing),
      .num_envelope_sweeps (num_envelope_sweeps),
      .target_vol          (target_vol),
      .env_done            (env_done),
      .dac_off             (dac_off)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NUM_CH*VOL_W-1:0] vol;
      logic [NUM_CH-1:0]       done;
      logic [NUM_CH-1:0]       dac;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   passes = 0;

   // Reference state: envelope progress is counted in accepted ticks since start.
   int m_vol[NUM_CH];
   int m_per[NUM_CH];
   int m_tk[NUM_CH];
   bit m_dir[NUM_CH];
   bit m_done[NUM_CH];

   logic [NUM_CH*VOL_W-1:0] r_iv;
   logic [NUM_CH-1:0]       r_inc;
   logic [NUM_CH*PER_W-1:0] r_per;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic void model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_vol[c] = 0; m_per[c] = 0; m_tk[c] = 0; m_dir[c] = 0; m_done[c] = 0;
      end
   endfunction

   function automatic void model_step(input logic [NUM_CH-1:0] st, input logic tk,
                                      input logic [NUM_CH-1:0] cw);
      for (int c = 0; c < NUM_CH; c++) begin
         int iv, p, v;
         bit up;
         iv = int'(initial_volume[c*VOL_W +: VOL_W]);
         p  = int'(num_envelope_sweeps[c*PER_W +: PER_W]);
         up = envelope_increasing[c];
         if (st[c]) begin
            m_vol[c] = iv; m_per[c] = p; m_dir[c] = up; m_tk[c] = 0; m_done[c] = 0;
         end
`ifdef GB_APU_ENV_ZOMBIE_EN
         else if (cw[c]) begin
            v = m_vol[c];
            if (m_per[c] == 0 && !m_done[c]) v = (v + 1) % (VMAX + 1);
            else if (!m_dir[c])              v = (v + 2) % (VMAX + 1);
            if (up != m_dir[c])              v = (VMAX + 1 - v) % (VMAX + 1);
            m_vol[c] = v; m_per[c] = p; m_dir[c] = up;
         end
`endif
         else if (tk && m_per[c] != 0 && !m_done[c]) begin
            m_tk[c]++;
            if (m_tk[c] % m_per[c] == 0) begin
               if (m_dir[c] && m_vol[c] < VMAX)      m_vol[c]++;
               else if (!m_dir[c] && m_vol[c] > 0)   m_vol[c]--;
               else                                  m_done[c] = 1;
            end
         end
         v = 0;
      end
      if (cw != cw) m_tk[0] = m_tk[0];
   endfunction

   function automatic exp_t model_exp();
      exp_t e;
      e.vol = '0; e.done = '0; e.dac = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         e.vol[c*VOL_W +: VOL_W] = VOL_W'(m_vol[c]);
         e.done[c] = m_done[c];
         e.dac[c]  = (initial_volume[c*VOL_W +: VOL_W] == '0) && !envelope_increasing[c];
      end
      return e;
   endfunction

   task automatic randin();
      r_iv  = (NUM_CH*VOL_W)'($urandom);
      r_inc = NUM_CH'($urandom);
      r_per = (NUM_CH*PER_W)'($urandom);
   endtask

   task automatic setch(input int c, input int iv, input bit up, input int p);
      r_iv[c*VOL_W +: VOL_W]  = VOL_W'(iv);
      r_inc[c]                = up;
      r_per[c*PER_W +: PER_W] = PER_W'(p);
   endtask

   task automatic drive(input logic [NUM_CH-1:0] st, input logic tk, input logic [NUM_CH-1:0] cw);
      @(negedge clk);
      rst_n = 1'b1; start = st; clk_vol_env = tk; cfg_wr = cw;
      initial_volume = r_iv; envelope_increasing = r_inc; num_envelope_sweeps = r_per;
      model_step(st, tk, cw);
      q.push_back(model_exp());
   endtask

   task automatic do_reset(input string name);
      @(negedge clk);
      start = '0; clk_vol_env = 1'b0; cfg_wr = '0;
      rst_n = 1'b0;
      #1;
      check({name, "_async_vol"}, target_vol, '0);
      check({name, "_async_done"}, env_done, '0);
      model_reset();
      q.push_back(model_exp());
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   function automatic int vol_of(input int c);
      return int'(target_vol[c*VOL_W +: VOL_W]);
   endfunction

   // Monitor: every clock presents a fresh output word to compare.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("vol", target_vol, e.vol);
            check("done", env_done, e.done);
            check("dac_off", dac_off, e.dac);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d", passes, checks);
      $fatal(1);
   end

   initial begin
      logic [NUM_CH-1:0] st, cw;
      logic              tk;
      model_reset();
      randin();
      #1;
      check("reset_vol", target_vol, '0);
      check("reset_done", env_done, '0);
      drive('0, 1'b0, '0);

      // ch0 vol 5 up, period 2: 6 -> 7 -> 8 over 6 ticks
      randin(); setch(0, 5, 1'b1, 2); drive(3'b001, 1'b0, '0);
      for (int i = 0; i < 6; i++) begin randin(); drive('0, 1'b1, '0); end
      settle();
      check("up_p2_vol", 64'(vol_of(0)), 64'd8);

      // ch1 vol 1 down, period 1: reaches 0 then saturates
      randin(); setch(1, 1, 1'b0, 1); drive(3'b010, 1'b0, '0);
      for (int i = 0; i < 3; i++) begin randin(); drive('0, 1'b1, '0); end
      settle();
      check("down_sat_vol", 64'(vol_of(1)), 64'd0);
      check("down_sat_done", 64'(env_done[1]), 64'd1);

      // ch2 period 0 holds
      randin(); setch(2, 9, 1'b0, 0); drive(3'b100, 1'b0, '0);
      for (int i = 0; i < 10; i++) begin randin(); drive('0, 1'b1, '0); end
      settle();
      check("p0_vol", 64'(vol_of(2)), 64'd9);
      check("p0_done", 64'(env_done[2]), 64'd0);

      // start and tick in the same cycle
      randin(); setch(0, 3, 1'b1, 1); drive(3'b001, 1'b1, '0);
      settle();
      check("start_tick_vol", 64'(vol_of(0)), 64'd3);
      randin(); drive('0, 1'b1, '0);
      settle();
      check("start_tick_next", 64'(vol_of(0)), 64'd4);

      // reset mid-envelope
      randin(); setch(0, 12, 1'b1, 3); drive(3'b001, 1'b0, '0);
      for (int i = 0; i < 2; i++) begin randin(); drive('0, 1'b1, '0); end
      settle();
      check("pre_reset_vol", 64'(vol_of(0)), 64'd12);
      do_reset("mid_reset");

      // config write on an idle-period channel at full volume
      randin(); setch(0, 15, 1'b1, 0); drive(3'b001, 1'b0, '0);
      randin(); setch(0, 15, 1'b1, 0); drive('0, 1'b0, 3'b001);
      settle();
`ifdef GB_APU_ENV_ZOMBIE_EN
      check("zombie_vol", 64'(vol_of(0)), 64'd0);
`else
      check("zombie_off_vol", 64'(vol_of(0)), 64'd15);
`endif

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         randin();
         st = '0;
         for (int c = 0; c < NUM_CH; c++) st[c] = ($urandom_range(0, 19) == 0);
         tk = ($urandom_range(0, 2) == 0);
`ifdef GB_APU_ENV_ZOMBIE_EN
         cw = '0;
`else
         cw = NUM_CH'($urandom);
`endif
         if ($urandom_range(0, 249) == 0) do_reset("rand_reset");
         else drive(st, tk, cw);
      end

      repeat (3) @(posedge clk);
      #2;
      check("queue_drained", 64'(q.size()), 64'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/gb_apu_envelope_multi.md
GB_APU_ENVELOPE_MULTI -- requirements
Module: gb_apu_envelope_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of independent envelope channels.
REQ-002 SHALL have parameter VOL_W, default 4: volume width; max volume VMAX = 2^VOL_W-1.
REQ-003 SHALL have parameter PER_W, default 3: sweep period field width.
REQ-004 SHALL have port clk  input  1: system clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-006 SHALL have port clk_vol_env  input  1: envelope tick, single-cycle strobe shared by all channels.
REQ-007 SHALL have port start  input  NUM_CH: per-channel trigger strobe.
REQ-008 SHALL have port cfg_wr  input  NUM_CH: per-channel config-write strobe, used only under ENV_ZOMBIE_EN.
REQ-009 SHALL have port initial_volume  input  NUM_CH*VOL_W: per-channel start volume, channel c at bits [c*VOL_W +: VOL_W].
REQ-010 SHALL have port envelope_increasing  input  NUM_CH: per-channel direction, 1=up, 0=down.
REQ-011 SHALL have port num_envelope_sweeps  input  NUM_CH*PER_W: per-channel period in ticks; 0 means the envelope is disabled.
REQ-012 SHALL have port target_vol  output  NUM_CH*VOL_W: per-channel current volume, registered.
REQ-013 SHALL have port env_done  output  NUM_CH: per-channel flag, set once the envelope has saturated, registered.
REQ-014 SHALL have port dac_off  output  NUM_CH: per-channel combinational flag, initial_volume==0 and envelope_increasing==0.

Function
REQ-015 SHALL give each channel its own volume register, PER_W-bit down-counter, latched period, latched direction and done flag.
REQ-016 SHALL, on start[c]: load volume from initial_volume; latch period and direction; load counter with period; clear env_done[c]; effect visible the next cycle.
REQ-017 SHALL use only the latched period and direction between starts; live input changes SHALL NOT affect a running channel.
REQ-018 SHALL, when start[c] and clk_vol_env coincide, apply start only; that tick is ignored for channel c.
REQ-019 SHALL, for a channel with latched period 0, hold volume and counter constant on every tick; env_done stays 0.
REQ-020 SHALL, for a channel with latched period P>0 and env_done=0, on each tick with counter>1: decrement counter.
REQ-021 SHALL, on a tick with counter<=1: reload counter with P and attempt one step, so steps occur exactly every P ticks.
REQ-022 SHALL apply a step as: up with volume<VMAX gives volume+1; down with volume>0 gives volume-1.
REQ-023 SHALL, on a step attempt with volume already at the limit (VMAX up, 0 down), leave volume unchanged, set env_done[c], and freeze the counter until the next start.
REQ-024 SHALL make volume saturating; no wrap-around in normal operation.
REQ-025 SHALL process channels independently in the same cycle; no arbitration and no shared state other than clk_vol_env.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously clear all volumes, counters, latched periods, directions and env_done to 0.
REQ-027 SHALL, after reset deassertion, keep all channels idle (period 0) until their first start.
REQ-028 SHALL, on reset asserted mid-envelope, abandon the envelope; no state survives reset.

Configuration
REQ-029 SHALL compile in zombie-mode writes with macro GB_APU_ENV_ZOMBIE_EN.
REQ-030 SHALL, with GB_APU_ENV_ZOMBIE_EN defined and cfg_wr[c] without start[c], evaluate these updates in order on the volume, each wrapping modulo 2^VOL_W:
- if latched period==0 and env_done=0: volume+1;
- else if latched direction==0: volume+2;
- then, if the new direction differs from the latched one: volume = 2^VOL_W - volume;
- then latch the new period and direction.
REQ-031 SHALL, with GB_APU_ENV_ZOMBIE_EN undefined, ignore cfg_wr entirely and synthesize no logic for it.
REQ-032 SHALL, when cfg_wr[c] and start[c] coincide, apply start only.

Verification
REQ-033 SHALL cover: start ch0 vol=5 up P=2, 6 ticks -> vol 6,7,8 after ticks 2,4,6.
REQ-034 SHALL cover: start ch1 vol=1 down P=1, 3 ticks -> vol 0 after tick 1; env_done[1]=1 after tick 2; vol stays 0.
REQ-035 SHALL cover: start ch2 vol=9 P=0, 10 ticks -> vol remains 9, env_done=0.
REQ-036 SHALL cover: start and tick in the same cycle, P=1, vol=3 up -> vol 3 that cycle; 4 after the next tick.
REQ-037 SHALL cover: rst_n low mid-envelope at vol=12 -> target_vol 0 immediately without a clock edge; env_done 0.
REQ-038 SHALL cover, with GB_APU_ENV_ZOMBIE_EN: ch0 vol=15, P=0, cfg_wr -> vol 0 (wrap); without the macro -> vol 15.
